// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants, types and helpers for the memory-access stage
package mem_access_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic f3_legal(input logic re, input logic we, input logic [2:0] f3);
        if (re && we) return 1'b0;
        if (re) return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
        if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return 1'b0;
    endfunction

    // Size lives in funct3[1:0] for both signed and unsigned loads.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_SB:   return {4{d[7:0]}};
            F3_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_SB:   return 4'b0001 << lane;
            F3_SH:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the stage and memory
interface mem_access_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strobe;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_strobe,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_strobe,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane selection with sign/zero extension
module load_extend
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory-access stage driving a req/ack data bus
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [2:0]                 funct3,
    input  logic                       memory_read_enable,
    input  logic                       memory_write_enable,
    input  logic [31:0]                mem_alu_result,
    input  logic [31:0]                reg2_data,
    mem_access_stage_if.master         bus,
    output logic                       mem_stall,
    output logic                       wb_valid,
    output logic [31:0]                wb_memory_read_data,
    output logic                       mem_fault,
    output logic [1:0]                 fault_cause
);

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic        we_q, we_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_strobe_q, bus_strobe_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        mem_op, illegal, misaligned, accept, busy, timeout_hit;
    logic [31:0] ext_data;

    load_extend u_load_extend (
        .funct3  (f3_q),
        .addr_lo (lane_q),
        .rdata   (bus.bus_rdata),
        .data    (ext_data)
    );

    always_comb begin
        busy        = (state_q == BUSY);
        mem_op      = ex_valid & (memory_read_enable | memory_write_enable);
        illegal     = mem_op & ~f3_legal(memory_read_enable, memory_write_enable, funct3);
        misaligned  = mem_op & ~illegal & is_misaligned(funct3, mem_alu_result[1:0]);
        accept      = ~busy & mem_op & ~illegal & ~misaligned;
        timeout_hit = busy & ~bus.bus_ack & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        // An aborted access releases upstream in the same cycle, just like an ack.
        mem_stall   = accept | (busy & ~bus.bus_ack & ~timeout_hit);
    end

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        we_d         = we_q;
        to_cnt_d     = to_cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_strobe_d = bus_strobe_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        fault_d      = 1'b0;
        cause_d      = FC_NONE;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = BUSY;
                    f3_d         = funct3;
                    lane_d       = mem_alu_result[1:0];
                    we_d         = memory_write_enable;
                    to_cnt_d     = '0;
                    bus_req_d    = 1'b1;
                    bus_we_d     = memory_write_enable;
                    bus_addr_d   = {mem_alu_result[31:2], 2'b00};
                    bus_wdata_d  = memory_write_enable ? store_wdata(funct3, reg2_data) : 32'h0;
                    bus_strobe_d = memory_write_enable ?
                                   store_strobe(funct3, mem_alu_result[1:0]) : 4'b0000;
                end else if (illegal) begin
                    fault_d = 1'b1;
                    cause_d = FC_ILLEGAL;
                end else if (misaligned) begin
                    fault_d = 1'b1;
                    cause_d = FC_MISALIGN;
                end
            end
            BUSY: begin
                if (bus.bus_ack || timeout_hit) begin
                    state_d      = IDLE;
                    bus_req_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = 32'h0;
                    bus_wdata_d  = 32'h0;
                    bus_strobe_d = 4'b0000;
                    to_cnt_d     = '0;
                end
                if (bus.bus_ack) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = we_q ? 32'h0 : ext_data;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            we_q         <= 1'b0;
            to_cnt_q     <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_strobe_q <= 4'b0000;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= 32'h0;
            fault_q      <= 1'b0;
            cause_q      <= FC_NONE;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            we_q         <= we_d;
            to_cnt_q     <= to_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_strobe_q <= bus_strobe_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
        end
    end

    assign bus.bus_req          = bus_req_q;
    assign bus.bus_we           = bus_we_q;
    assign bus.bus_addr         = bus_addr_q;
    assign bus.bus_wdata        = bus_wdata_q;
    assign bus.bus_strobe       = bus_strobe_q;
    assign wb_valid             = wb_valid_q;
    assign wb_memory_read_data  = wb_data_q;
    assign mem_fault            = fault_q;
    assign fault_cause          = cause_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  funct3;
    logic        memory_read_enable;
    logic        memory_write_enable;
    logic [31:0] mem_alu_result;
    logic [31:0] reg2_data;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_memory_read_data;
    logic        mem_fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;
    int stalls;
    int reqs;

    mem_access_stage_if bif ();

    mem_access_stage #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_valid            (ex_valid),
        .funct3              (funct3),
        .memory_read_enable  (memory_read_enable),
        .memory_write_enable (memory_write_enable),
        .mem_alu_result      (mem_alu_result),
        .reg2_data           (reg2_data),
        .bus                 (bif.master),
        .mem_stall           (mem_stall),
        .wb_valid            (wb_valid),
        .wb_memory_read_data (wb_memory_read_data),
        .mem_fault           (mem_fault),
        .fault_cause         (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        ex_valid            = v;
        memory_read_enable  = re;
        memory_write_enable = we;
        funct3              = f3;
        mem_alu_result      = addr;
        reg2_data           = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Issue a request in IDLE that must be rejected, then check the fault pulse.
    task automatic reject(input string tag, input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] cause);
        @(negedge clk);
        drive(1'b1, re, we, f3, addr, 32'h0);
        #1 chk({tag, "_stall"}, mem_stall, 0);
        @(negedge clk);
        idle_inputs();
        chk({tag, "_fault"}, mem_fault, 1);
        chk({tag, "_cause"}, fault_cause, cause);
        chk({tag, "_req"}, bif.bus_req, 0);
    endtask

    // Load accepted, acked on the first BUSY cycle; checks the extended result.
    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rd, input logic [31:0] exp);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, f3, addr, 32'h0);
        @(negedge clk);
        chk({tag, "_addr"}, bif.bus_addr, {addr[31:2], 2'b00});
        bif.bus_ack = 1'b1;
        bif.bus_rdata = rd;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        idle_inputs();
        chk({tag, "_wbv"}, wb_valid, 1);
        chk({tag, "_wbd"}, wb_memory_read_data, exp);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", bif.bus_req, 0);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_strobe", bif.bus_strobe, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_fault", {mem_fault, fault_cause}, 0);
        rst = 1'b0;

        // LB 0x103 with ack after three waiting BUSY cycles
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        stalls = 0;
        #1 if (mem_stall) stalls++;
        @(negedge clk);
        chk("lb_req", bif.bus_req, 1);
        chk("lb_we", bif.bus_we, 0);
        chk("lb_addr", bif.bus_addr, 32'h100);
        chk("lb_strobe", bif.bus_strobe, 4'b0000);
        #1 if (mem_stall) stalls++;
        repeat (2) begin
            @(negedge clk);
            #1 if (mem_stall) stalls++;
        end
        @(negedge clk);
        chk("lb_req_hold", bif.bus_req, 1);
        bif.bus_ack = 1'b1;
        bif.bus_rdata = 32'h80FF_1234;
        #1 chk("lb_ack_stall", mem_stall, 0);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        idle_inputs();
        chk("lb_stalls", stalls, 4);
        chk("lb_wbv", wb_valid, 1);
        chk("lb_wbd", wb_memory_read_data, 32'hFFFF_FF80);
        chk("lb_req_drop", bif.bus_req, 0);
        @(negedge clk);
        chk("lb_wbv_pulse", wb_valid, 0);

        // SH 0x202 with immediate ack
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
        #1 chk("sh_stall", mem_stall, 1);
        @(negedge clk);
        chk("sh_we", bif.bus_we, 1);
        chk("sh_addr", bif.bus_addr, 32'h200);
        chk("sh_wdata", bif.bus_wdata, 32'hBEEF_BEEF);
        chk("sh_strobe", bif.bus_strobe, 4'b1100);
        bif.bus_ack = 1'b1;
        bif.bus_rdata = 32'hFFFF_FFFF;
        #1 chk("sh_ack_stall", mem_stall, 0);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        idle_inputs();
        chk("sh_wbv", wb_valid, 1);
        chk("sh_wbd", wb_memory_read_data, 0);

        // SB lane 1
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h1234_56A5);
        @(negedge clk);
        chk("sb_wdata", bif.bus_wdata, 32'hA5A5_A5A5);
        chk("sb_strobe", bif.bus_strobe, 4'b0010);
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        idle_inputs();

        quick_load("lh", 3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF);
        quick_load("lbu", 3'b100, 32'h0000_0101, 32'h80FF_12F4, 32'h0000_0012);
        quick_load("lhu", 3'b101, 32'h0000_0100, 32'h0000_9234, 32'h0000_9234);

        reject("lhu_mis", 1'b1, 1'b0, 3'b101, 32'h0000_0201, 2'b01);
        reject("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0302, 2'b01);
        reject("ld_f3", 1'b1, 1'b0, 3'b011, 32'h0000_0300, 2'b10);
        reject("both_en", 1'b1, 1'b1, 3'b010, 32'h0000_0300, 2'b10);
        reject("both_mis", 1'b1, 1'b1, 3'b010, 32'h0000_0301, 2'b10);

        // Non-memory instruction plus a stale ack in IDLE
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        bif.bus_ack = 1'b1;
        #1 chk("nonmem_stall", mem_stall, 0);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        idle_inputs();
        chk("nonmem_req", bif.bus_req, 0);
        chk("nonmem_wbv_fault", {wb_valid, mem_fault}, 0);

        // LW with no ack: abort after 16 BUSY cycles
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        stalls = 0;
        reqs = 0;
        #1 if (mem_stall) stalls++;
        repeat (16) begin
            @(negedge clk);
            if (bif.bus_req) reqs++;
            #1 if (mem_stall) stalls++;
        end
        chk("to_stall_release", mem_stall, 0);
        @(negedge clk);
        idle_inputs();
        chk("to_reqs", reqs, 16);
        chk("to_stalls", stalls, 16);
        chk("to_req_drop", bif.bus_req, 0);
        chk("to_fault", mem_fault, 1);
        chk("to_cause", fault_cause, 2'b11);
        chk("to_wbv", wb_valid, 0);
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        chk("late_ack_wbv", wb_valid, 0);
        chk("late_ack_fault", mem_fault, 0);

        // Reset on the second BUSY cycle, then an ack
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        bif.bus_ack = 1'b1;
        bif.bus_rdata = 32'hCAFE_F00D;
        chk("mrst_req", bif.bus_req, 0);
        chk("mrst_addr", bif.bus_addr, 0);
        chk("mrst_wbd", wb_memory_read_data, 0);
        #1 chk("mrst_stall", mem_stall, 0);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        chk("mrst_wbv", wb_valid, 0);
        chk("mrst_fault", mem_fault, 0);

        quick_load("lw_after", 3'b010, 32'h0000_0600, 32'h1234_5678, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
